aes_inv_round_ctrl: RTL and testbench

- Iterative sequencer for the AES inverse cipher.
- Owns the 128-bit state register and time-shares one combinational inverse-round datapath (inverse shift rows, inverse sub bytes, add round key, inverse mix columns) over all NR rounds.
- Fetches round keys from the key-schedule store by address.
- Sits between the block-level valid/ready input and output streams of the decrypt path.

---
 rtl/aes_inv_round_ctrl_if.sv | 19 +
 rtl/aes_inv_round_ctrl.sv | 94 +++++++++
 tb/tb_aes_inv_round_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_round_ctrl_if.sv
// Valid/ready stream pair of the AES decrypt path: ciphertext in, plaintext out.
interface aes_inv_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer: owns the state register and drives
// one shared combinational inverse-round datapath for NR rounds per block.
module aes_inv_round_ctrl #(
    parameter int NR  = 10,
    parameter int KAW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_round_ctrl_if.slave  strm,
    output logic [KAW-1:0]       key_addr,
    input  logic [127:0]         key_data,
    output logic [127:0]         rd_din,
    output logic                 rd_last,
    input  logic [127:0]         rd_dout,
    output logic                 busy,
    output logic [KAW-1:0]       rnd
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    localparam logic [KAW-1:0] RND_NR  = KAW'(NR);
    localparam logic [KAW-1:0] RND_ONE = KAW'(1);

    state_t         st_q, st_d;
    logic [127:0]   state_q, state_d;
    logic [KAW-1:0] rnd_q, rnd_d;
    logic           in_ready_c;
    logic           out_valid_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            state_q <= '0;
            rnd_q   <= RND_NR;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        state_d     = state_q;
        rnd_d       = rnd_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        key_addr    = rnd_q;
        rd_last     = 1'b0;
        case (st_q)
            IDLE: begin
                in_ready_c = 1'b1;
                key_addr   = RND_NR;
                // Initial AddRoundKey with rk[NR] is folded into the accept edge.
                if (strm.in_valid) begin
                    state_d = strm.in_data ^ key_data;
                    rnd_d   = RND_NR - RND_ONE;
                    st_d    = ROUND;
                end
            end
            ROUND: begin
                rd_last = (rnd_q == '0);
                state_d = rd_dout;
                if (rnd_q == '0) begin
                    st_d = DONE;
                end else begin
                    rnd_d = rnd_q - RND_ONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (strm.out_ready) begin
                    st_d  = IDLE;
                    rnd_d = RND_NR;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    assign strm.in_ready  = in_ready_c;
    assign strm.out_valid = out_valid_c;
    assign strm.out_data  = state_q;
    assign rd_din         = state_q;
    assign busy           = (st_q == ROUND) || (st_q == DONE);
    assign rnd            = rnd_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: NR=10 and NR=14 instances with behavioural key
// store and inverse-round datapath, FIPS-197 vectors and a plaintext scoreboard.
module tb_aes_inv_round_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk10  [16];
    logic [127:0] rk14  [16];
    logic [127:0] sb10  [$];
    logic [127:0] sb14  [$];

    aes_inv_round_ctrl_if if10();
    aes_inv_round_ctrl_if if14();

    logic [3:0]   key_addr10, key_addr14, rnd10, rnd14;
    logic [127:0] key_data10, key_data14, rd_din10, rd_din14, rd_dout10, rd_dout14;
    logic         rd_last10, rd_last14, busy10, busy14;

    aes_inv_round_ctrl #(.NR(10), .KAW(4)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .strm(if10.slave),
        .key_addr(key_addr10), .key_data(key_data10),
        .rd_din(rd_din10), .rd_last(rd_last10), .rd_dout(rd_dout10),
        .busy(busy10), .rnd(rnd10)
    );

    aes_inv_round_ctrl #(.NR(14), .KAW(4)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .strm(if14.slave),
        .key_addr(key_addr14), .key_data(key_data14),
        .rd_din(rd_din14), .rd_last(rd_last14), .rd_dout(rd_dout14),
        .busy(busy14), .rnd(rnd14)
    );

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 60; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endfunction

    // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   f [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[4*c+rr] = isbox[a[4*((c-rr+4)%4)+rr]] ^ k[127-8*(4*c+rr) -: 8];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int rr = 0; rr < 4; rr++) f[4*c+rr] = t[4*c+rr];
            end else begin
                f[4*c+0] = gmul(t[4*c],8'h0e) ^ gmul(t[4*c+1],8'h0b) ^ gmul(t[4*c+2],8'h0d) ^ gmul(t[4*c+3],8'h09);
                f[4*c+1] = gmul(t[4*c],8'h09) ^ gmul(t[4*c+1],8'h0e) ^ gmul(t[4*c+2],8'h0b) ^ gmul(t[4*c+3],8'h0d);
                f[4*c+2] = gmul(t[4*c],8'h0d) ^ gmul(t[4*c+1],8'h09) ^ gmul(t[4*c+2],8'h0e) ^ gmul(t[4*c+3],8'h0b);
                f[4*c+3] = gmul(t[4*c],8'h0b) ^ gmul(t[4*c+1],8'h0d) ^ gmul(t[4*c+2],8'h09) ^ gmul(t[4*c+3],8'h0e);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = f[i];
        return r;
    endfunction

    function automatic logic [127:0] ref_decrypt10(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk10[10];
        for (int r = 9; r >= 0; r--) s = inv_round(s, rk10[r], r == 0);
        return s;
    endfunction

    assign key_data10 = rk10[key_addr10];
    assign key_data14 = rk14[key_addr14];
    assign rd_dout10  = inv_round(rd_din10, key_data10, rd_last10);
    assign rd_dout14  = inv_round(rd_din14, key_data14, rd_last14);

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic build_tables;
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
        for (int k = 0; k < 16; k++) begin
            rk10[k] = (k <= 10) ? round_key(K128, 4, k) : '0;
            rk14[k] = (k <= 14) ? round_key(K256, 8, k) : '0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        if10.in_valid = 1'b0; if10.out_ready = 1'b1;
        if14.in_valid = 1'b0; if14.out_ready = 1'b1;
        step(); step();
        checks++; if (if10.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", if10.in_ready); end
        checks++; if (if10.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", if10.out_valid); end
        checks++; if (busy10 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy10); end
        checks++; if (rnd10 !== 4'd10) begin errors++; $display("FAIL rst_rnd: got %0d expected 10", rnd10); end
        checks++; if (if10.out_data !== 128'h0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", if10.out_data); end
        checks++; if (rd_din10 !== 128'h0) begin errors++; $display("FAIL rst_rd_din: got %h expected 0", rd_din10); end
        checks++; if (rd_last10 !== 1'b0) begin errors++; $display("FAIL rst_rd_last: got %b expected 0", rd_last10); end
        checks++; if (key_addr10 !== 4'd10) begin errors++; $display("FAIL rst_key_addr: got %0d expected 10", key_addr10); end
        checks++; if (rnd14 !== 4'd14) begin errors++; $display("FAIL rst_rnd14: got %0d expected 14", rnd14); end
        checks++; if (if14.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready14: got %b expected 1", if14.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_c1_decrypt;
        int ca, k;
        logic [127:0] exp_v;
        if10.in_data = CT1; if10.in_valid = 1'b1; if10.out_ready = 1'b1;
        k = 0;
        while (!if10.in_ready && k < 20) begin step(); k++; end
        checks++; if (if10.in_ready !== 1'b1) begin errors++; $display("FAIL c1_accept_timeout: got in_ready %b expected 1", if10.in_ready); end
        checks++; if (key_addr10 !== 4'd10 || rd_last10 !== 1'b0) begin errors++; $display("FAIL c1_key_idle: got addr %0d last %b expected addr 10 last 0", key_addr10, rd_last10); end
        sb10.push_back(PT);
        ca = cyc;
        step();
        if10.in_valid = 1'b0;
        if10.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int r = 9; r >= 0; r--) begin
            checks++;
            if (key_addr10 !== 4'(r) || rd_last10 !== (r == 0) || busy10 !== 1'b1 || if10.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL c1_key_seq: got addr %0d last %b busy %b ov %b expected addr %0d last %b busy 1 ov 0",
                         key_addr10, rd_last10, busy10, if10.out_valid, r, r == 0);
            end
            step();
        end
        k = 0;
        while (!if10.out_valid && k < 30) begin step(); k++; end
        checks++; if ((cyc - ca) != 11) begin errors++; $display("FAIL c1_latency: got %0d cycles expected 11", cyc - ca); end
        checks++; if (rd_last10 !== 1'b0) begin errors++; $display("FAIL c1_rd_last_done: got %b expected 0", rd_last10); end
        exp_v = sb10.pop_front();
        checks++; if (if10.out_data !== exp_v) begin errors++; $display("FAIL c1_plaintext: got %h expected %h", if10.out_data, exp_v); end
        step();
        checks++; if (if10.out_valid !== 1'b0 || if10.in_ready !== 1'b1) begin errors++; $display("FAIL c1_pulse: got ov %b ir %b expected ov 0 ir 1", if10.out_valid, if10.in_ready); end
    endtask

    task automatic test_backpressure;
        int k;
        logic [127:0] exp_v;
        if10.in_data = CT1; if10.in_valid = 1'b1; if10.out_ready = 1'b0;
        k = 0;
        while (!if10.in_ready && k < 20) begin step(); k++; end
        sb10.push_back(PT);
        step();
        if10.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        k = 0;
        while (!if10.out_valid && k < 30) begin step(); k++; end
        checks++; if (if10.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_timeout: got ov %b expected 1", if10.out_valid); end
        exp_v = sb10.pop_front();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (if10.out_data !== exp_v || if10.out_valid !== 1'b1 || if10.in_ready !== 1'b0 || busy10 !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: got data %h ov %b ir %b busy %b expected data %h ov 1 ir 0 busy 1",
                         if10.out_data, if10.out_valid, if10.in_ready, busy10, exp_v);
            end
            step();
        end
        if10.out_ready = 1'b1;
        if10.in_valid = 1'b0;
        checks++; if (if10.out_data !== exp_v) begin errors++; $display("FAIL bp_release_data: got %h expected %h", if10.out_data, exp_v); end
        step();
        checks++;
        if (if10.in_ready !== 1'b1 || busy10 !== 1'b0 || if10.out_valid !== 1'b0 || rnd10 !== 4'd10) begin
            errors++;
            $display("FAIL bp_idle: got ir %b busy %b ov %b rnd %0d expected ir 1 busy 0 ov 0 rnd 10",
                     if10.in_ready, busy10, if10.out_valid, rnd10);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] ctb, expb, exp_v;
        int acc_cyc [2];
        int n_acc, n_out;
        bit acc, ohs;
        ctb = {$urandom(), $urandom(), $urandom(), $urandom()};
        expb = ref_decrypt10(ctb);
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        n_acc = 0; n_out = 0;
        if10.in_data = CT1; if10.in_valid = 1'b1; if10.out_ready = 1'b1;
        for (int k = 0; k < 80 && n_out < 2; k++) begin
            acc = if10.in_valid && if10.in_ready;
            ohs = if10.out_valid && if10.out_ready;
            if (acc) begin
                sb10.push_back(n_acc == 0 ? PT : expb);
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (ohs) begin
                checks++;
                if (sb10.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got output %h expected none", if10.out_data);
                end else begin
                    exp_v = sb10.pop_front();
                    if (if10.out_data !== exp_v) begin errors++; $display("FAIL b2b_plaintext: got %h expected %h", if10.out_data, exp_v); end
                end
                n_out++;
            end
            step();
            if (acc) begin
                if (n_acc == 1) if10.in_data = ctb;
                else if10.in_valid = 1'b0;
            end
        end
        if10.in_valid = 1'b0;
        checks++; if (n_out != 2) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 2", n_out); end
        checks++; if (acc_cyc[1] - acc_cyc[0] != 12) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected 12", acc_cyc[1] - acc_cyc[0]); end
    endtask

    task automatic test_reset_mid_round;
        int k;
        bit seen;
        if10.in_data = CT1; if10.in_valid = 1'b1; if10.out_ready = 1'b1;
        k = 0;
        while (!if10.in_ready && k < 20) begin step(); k++; end
        step();
        if10.in_valid = 1'b0;
        k = 0;
        while (rnd10 !== 4'd5 && k < 20) begin step(); k++; end
        checks++; if (rnd10 !== 4'd5 || busy10 !== 1'b1) begin errors++; $display("FAIL rmr_reach: got rnd %0d busy %b expected rnd 5 busy 1", rnd10, busy10); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (if10.in_ready !== 1'b1 || rnd10 !== 4'd10 || busy10 !== 1'b0 || if10.out_valid !== 1'b0 || if10.out_data !== 128'h0) begin
            errors++;
            $display("FAIL rmr_state: got ir %b rnd %0d busy %b ov %b data %h expected ir 1 rnd 10 busy 0 ov 0 data 0",
                     if10.in_ready, rnd10, busy10, if10.out_valid, if10.out_data);
        end
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (if10.out_valid) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmr_no_output: got out_valid pulse %b expected 0", seen); end
        test_c1_decrypt();
    endtask

    task automatic test_nr14;
        int ca, k;
        logic [127:0] exp_v;
        if14.in_data = CT3; if14.in_valid = 1'b1; if14.out_ready = 1'b1;
        k = 0;
        while (!if14.in_ready && k < 20) begin step(); k++; end
        checks++; if (key_addr14 !== 4'd14) begin errors++; $display("FAIL nr14_key_idle: got %0d expected 14", key_addr14); end
        sb14.push_back(PT);
        ca = cyc;
        step();
        if14.in_valid = 1'b0;
        for (int r = 13; r >= 0; r--) begin
            checks++;
            if (key_addr14 !== 4'(r) || rd_last14 !== (r == 0)) begin
                errors++;
                $display("FAIL nr14_key_seq: got addr %0d last %b expected addr %0d last %b", key_addr14, rd_last14, r, r == 0);
            end
            step();
        end
        k = 0;
        while (!if14.out_valid && k < 40) begin step(); k++; end
        checks++; if ((cyc - ca) != 15) begin errors++; $display("FAIL nr14_latency: got %0d cycles expected 15", cyc - ca); end
        exp_v = sb14.pop_front();
        checks++; if (if14.out_data !== exp_v) begin errors++; $display("FAIL nr14_plaintext: got %h expected %h", if14.out_data, exp_v); end
        step();
        checks++; if (if14.out_valid !== 1'b0 || rnd14 !== 4'd14) begin errors++; $display("FAIL nr14_idle: got ov %b rnd %0d expected ov 0 rnd 14", if14.out_valid, rnd14); end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_c1_decrypt();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_round();
        test_nr14();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
